// File: rtl/poly94_sdram_pkg.sv
`default_nettype none
// ============================================================================
// Module   : poly94_sdram_pkg
// Brief    : Shared SDRAM arbiter types and bus widths.
// Revision : 1.0
// ============================================================================
package poly94_sdram_pkg;

    localparam int SDRAM_ADDR_W = 24;
    localparam int SDRAM_DATA_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef enum logic {
        OWN_VID = 1'b0,
        OWN_CPU = 1'b1
    } owner_t;

endpackage
`default_nettype wire

// File: rtl/sdram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sdram_arbiter
// Brief    : Video-burst / CPU-word arbiter in front of one SDRAM controller.
// Revision : 1.0
// ============================================================================
module sdram_arbiter
    import poly94_sdram_pkg::*;
#(
    parameter int VID_MAX_CONSEC = 4,
    parameter int BURST_LEN      = 64
) (
    input  logic                    clk_i,
    input  logic                    rst_i,

    input  logic                    vid_cmd_valid_i,
    output logic                    vid_cmd_ready_o,
    input  logic [SDRAM_ADDR_W-1:0] vid_addr_x16_i,
    output logic                    vid_resp_valid_o,
    output logic                    vid_resp_last_o,

    input  logic                    cpu_cmd_valid_i,
    output logic                    cpu_cmd_ready_o,
    input  logic [SDRAM_ADDR_W-1:0] cpu_addr_x16_i,
    input  logic                    cpu_we_i,
    input  logic [SDRAM_DATA_W-1:0] cpu_wdata_i,
    input  logic [1:0]              cpu_wmask_i,
    output logic                    cpu_resp_valid_o,

    output logic [SDRAM_DATA_W-1:0] rdata_o,

    output logic                    mem_cmd_valid_o,
    input  logic                    mem_cmd_ready_i,
    output logic [SDRAM_ADDR_W-1:0] mem_addr_x16_o,
    output logic                    mem_we_o,
    output logic [SDRAM_DATA_W-1:0] mem_wdata_o,
    output logic [1:0]              mem_wmask_o,
    output logic                    mem_burst_o,
    input  logic                    mem_resp_valid_i,
    input  logic                    mem_resp_last_i,
    input  logic [SDRAM_DATA_W-1:0] mem_rdata_i
);

    localparam int STREAK_W = $clog2(VID_MAX_CONSEC + 1);

    generate
        if (BURST_LEN < 1 || VID_MAX_CONSEC < 1) begin : g_param_check
            $error("sdram_arbiter: BURST_LEN and VID_MAX_CONSEC must be >= 1");
        end
    endgenerate

    state_t                  r_state;
    owner_t                  r_owner;
    logic [STREAK_W-1:0]     r_streak;
    logic                    r_armed;
    logic [SDRAM_ADDR_W-1:0] r_addr;
    logic                    r_we;
    logic [SDRAM_DATA_W-1:0] r_wdata;
    logic [1:0]              r_wmask;
    logic                    r_burst;

    logic w_in_cmd;
    logic w_in_resp;
    logic w_vid_wins;
    logic w_streak_full;

    assign w_streak_full = (r_streak >= STREAK_W'(VID_MAX_CONSEC));
    assign w_vid_wins    = vid_cmd_valid_i && (!cpu_cmd_valid_i || !w_streak_full);

    // r_armed keeps the first edge after reset release decision-free, so the
    // earliest grant lands on the second edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state  <= ST_IDLE;
            r_owner  <= OWN_VID;
            r_streak <= '0;
            r_armed  <= 1'b0;
            r_addr   <= '0;
            r_we     <= 1'b0;
            r_wdata  <= '0;
            r_wmask  <= '0;
            r_burst  <= 1'b0;
        end else begin
            r_armed <= 1'b1;
            case (r_state)
                ST_IDLE: begin
                    if (r_armed) begin
                        if (w_vid_wins) begin
                            r_owner <= OWN_VID;
                            r_state <= ST_CMD;
                            r_addr  <= vid_addr_x16_i;
                            r_we    <= 1'b0;
                            r_wdata <= '0;
                            r_wmask <= 2'b11;
                            r_burst <= 1'b1;
                        end else if (cpu_cmd_valid_i) begin
                            r_owner <= OWN_CPU;
                            r_state <= ST_CMD;
                            r_addr  <= cpu_addr_x16_i;
                            r_we    <= cpu_we_i;
                            r_wdata <= cpu_wdata_i;
                            r_wmask <= cpu_wmask_i;
                            r_burst <= 1'b0;
                        end
                    end
                end
                ST_CMD: begin
                    if (mem_cmd_ready_i) begin
                        if (r_owner == OWN_VID) begin
                            if (cpu_cmd_valid_i && !w_streak_full)
                                r_streak <= r_streak + STREAK_W'(1);
                            r_state <= ST_RESP;
                        end else begin
                            r_streak <= '0;
                            r_state  <= r_we ? ST_IDLE : ST_RESP;
                        end
                    end
                end
                ST_RESP: begin
                    if (mem_resp_valid_i && mem_resp_last_i)
                        r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_in_cmd  = (r_state == ST_CMD);
        w_in_resp = (r_state == ST_RESP);
    end

    assign mem_cmd_valid_o  = w_in_cmd;
    assign mem_addr_x16_o   = r_addr;
    assign mem_we_o         = r_we;
    assign mem_wdata_o      = r_wdata;
    assign mem_wmask_o      = r_wmask;
    assign mem_burst_o      = r_burst;

    assign vid_cmd_ready_o  = w_in_cmd && (r_owner == OWN_VID) && mem_cmd_ready_i;
    assign cpu_cmd_ready_o  = w_in_cmd && (r_owner == OWN_CPU) && mem_cmd_ready_i;

    assign vid_resp_valid_o = w_in_resp && (r_owner == OWN_VID) && mem_resp_valid_i;
    assign vid_resp_last_o  = vid_resp_valid_o && mem_resp_last_i;
    assign cpu_resp_valid_o = w_in_resp && (r_owner == OWN_CPU) && mem_resp_valid_i;

    assign rdata_o          = mem_rdata_i;

endmodule
`default_nettype wire
